reg_share_arb: RTL and testbench

REG_SHARE_ARB -- requirements
Module: reg_share_arb

---
 rtl/reg_share_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 33 +++
 rtl/reg_share_arb.sv | 125 ++++++++++++
 tb/tb_reg_share_arb.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_share_arb_pkg.sv
// Shared definitions for the register-sharing arbiter: FSM encodings,
// default sizing and a small width helper.
package reg_share_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int HOLD_DEF  = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above ptr,
// wrapping from the top requester back to requester 0.
module rr_pick
  import reg_share_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win_oh,
  output logic [IDX_W-1:0] win_idx
);

  logic found;
  int   cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!found && req[cand]) begin
        found        = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/reg_share_arb.sv
// Round-robin arbiter that lets NREQ requesters take turns writing one shared
// register, with a post-write hold window before the next arbitration.
module reg_share_arb
  import reg_share_arb_pkg::*;
#(
  parameter int  NREQ  = NREQ_DEF,
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  HOLD  = HOLD_DEF,
  localparam int IDX_W = idx_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [IDX_W-1:0]      q_owner,
  output logic                  q_valid,
  output logic                  busy
);

  localparam int              CNT_W    = idx_w(HOLD);
  localparam logic [CNT_W-1:0] CNT_INIT = (HOLD > 0) ? CNT_W'(HOLD - 1) : '0;

  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             arst_n;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d;
  logic [NREQ-1:0]  win_oh_q, win_oh_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic             valid_q, valid_d;

  logic [NREQ-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;

  // Reset asserts immediately but releases only after two clock edges.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign arst_n     = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    win_idx_d = win_idx_q;
    win_oh_d  = win_oh_q;
    data_d    = data_q;
    owner_d   = owner_q;
    valid_d   = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          win_idx_d = pick_idx;
          win_oh_d  = pick_oh;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The winner is committed: data is taken even if its req has dropped.
        data_d  = wdata[int'(win_idx_q)*WIDTH +: WIDTH];
        owner_d = win_idx_q;
        valid_d = 1'b1;
        ptr_d   = (win_idx_q == IDX_W'(NREQ - 1)) ? '0 : win_idx_q + IDX_W'(1);
        if (HOLD > 0) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      win_idx_q <= '0;
      win_oh_q  <= '0;
      data_q    <= '0;
      owner_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      win_idx_q <= win_idx_d;
      win_oh_q  <= win_oh_d;
      data_q    <= data_d;
      owner_q   <= owner_d;
      valid_q   <= valid_d;
    end
  end

  assign gnt     = (state_q == ST_WRITE) ? win_oh_q : '0;
  assign busy    = (state_q != ST_IDLE);
  assign q       = data_q;
  assign q_owner = owner_q;
  assign q_valid = valid_q;

endmodule

// File: tb/tb_reg_share_arb.sv
// Directed bench for reg_share_arb: a timeline model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_reg_share_arb;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 8;
  localparam int HOLD_P = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req   = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  q_owner;
  logic        q_valid;
  logic        busy;

  logic [3:0]  req2   = '0;
  logic [31:0] wdata2 = '0;
  logic [3:0]  gnt2;
  logic [7:0]  q2;
  logic [1:0]  q_owner2;
  logic        q_valid2;
  logic        busy2;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b1;

  always #5 clk = ~clk;

  reg_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD_P)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt), .q(q), .q_owner(q_owner), .q_valid(q_valid), .busy(busy)
  );

  reg_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req2), .wdata(wdata2),
    .gnt(gnt2), .q(q2), .q_owner(q_owner2), .q_valid(q_valid2), .busy(busy2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: m_since = cycles since the winner was picked, -1 when idle.
  int         m_since = -1;
  int         m_ptr   = 0;
  int         m_win   = 0;
  logic [7:0] m_q     = '0;
  int         m_own   = 0;
  bit         m_val   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_since = -1; m_ptr = 0; m_win = 0; m_q = '0; m_own = 0; m_val = 1'b0;
    end else begin
      if (m_since == 0) begin
        m_q   = wdata[m_win*8 +: 8];
        m_own = m_win;
        m_val = 1'b1;
        m_ptr = (m_win + 1) % NREQ;
      end
      if (m_since >= 0) begin
        m_since++;
        if (m_since > HOLD_P) m_since = -1;
      end else if (req != 0) begin
        for (int k = NREQ - 1; k >= 0; k--)
          if (req[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
        m_since = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_gnt",   int'(gnt),     (m_since == 0) ? (1 << m_win) : 0);
      chk("m_busy",  int'(busy),    (m_since >= 0) ? 1 : 0);
      chk("m_q",     int'(q),       int'(m_q));
      chk("m_owner", int'(q_owner), m_own);
      chk("m_valid", int'(q_valid), int'(m_val));
    end
  end

  task automatic wait_gnt(output int idx, output int n);
    bit found = 1'b0;
    idx = -1;
    n   = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      n++;
      if (gnt != 0) begin
        idx   = $clog2(gnt);
        found = 1'b1;
      end
    end
    if (!found) chk("gnt_timeout", 0, 1);
  endtask

  int gi, gn;
  int gseq[$];
  int qseq[$];
  bit prev_g;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_valid", int'(q_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // All four requesting: rotate 0,1,2,3,0.
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req   = 4'b1111;
    prev_g = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (prev_g) qseq.push_back(int'(q));
      prev_g = (gnt != 0);
      if (gnt != 0) gseq.push_back($clog2(gnt));
      if (i == 19) req = '0;
    end
    chk("rr_count", gseq.size(), 5);
    chk("rr_qcount", qseq.size(), 5);
    if (gseq.size() == 5 && qseq.size() == 5) begin
      chk("rr_g0", gseq[0], 0); chk("rr_g1", gseq[1], 1); chk("rr_g2", gseq[2], 2);
      chk("rr_g3", gseq[3], 3); chk("rr_g4", gseq[4], 0);
      chk("rr_q0", qseq[0], 'h11); chk("rr_q1", qseq[1], 'h22); chk("rr_q2", qseq[2], 'h33);
      chk("rr_q3", qseq[3], 'h44); chk("rr_q4", qseq[4], 'h11);
    end
    repeat (2) @(negedge clk);

    // Single requester held: grant every HOLD+2 cycles.
    wdata = {24'h0, 8'hA5};
    req   = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("single_gnt", int'(gnt), (i % 4 == 0) ? 1 : 0);
      if (i == 1) begin
        chk("single_q", int'(q), 'hA5);
        chk("single_owner", int'(q_owner), 0);
        chk("single_valid", int'(q_valid), 1);
      end
      if (i == 8) req = '0;
    end
    repeat (3) @(negedge clk);

    // Pointer wrap after a grant to requester 3.
    req = 4'b1000;
    wait_gnt(gi, gn);
    chk("wrap_g3", gi, 3);
    req = '0;
    repeat (3) @(negedge clk);
    req = 4'b1001;
    wait_gnt(gi, gn);
    chk("wrap_first", gi, 0);
    wait_gnt(gi, gn);
    chk("wrap_second", gi, 3);
    req = '0;
    repeat (3) @(negedge clk);

    // Request raised during HOLD is served at the first IDLE edge.
    req = 4'b0001;
    wait_gnt(gi, gn);
    chk("late_g0", gi, 0);
    req = '0;
    @(negedge clk);
    req = 4'b0010;
    wait_gnt(gi, gn);
    chk("late_g1", gi, 1);
    chk("late_gap", gn, 3);
    req = '0;
    repeat (3) @(negedge clk);

    // Reset mid-HOLD clears everything without a clock edge.
    wdata = {24'h0, 8'h5A};
    req   = 4'b0001;
    wait_gnt(gi, gn);
    req = '0;
    @(negedge clk);
    chk("hold_q", int'(q), 'h5A);
    chk("hold_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_q", int'(q), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_valid", int'(q_valid), 0);
    chk("async_owner", int'(q_owner), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    req = 4'b0100;
    wait_gnt(gi, gn);
    chk("post_rst_g2", gi, 2);
    req = '0;
    repeat (3) @(negedge clk);

    // Requests present at reset release: no arbitration at the first edge.
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_edge1_gnt", int'(gnt), 0);
    chk("rel_edge1_busy", int'(busy), 0);
    wait_gnt(gi, gn);
    chk("rel_first_g0", gi, 0);
    req = '0;
    repeat (4) @(negedge clk);

    // HOLD=0: grant every second cycle, busy only during WRITE.
    wdata2 = {16'h0, 8'h3C, 8'h0};
    req2   = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("h0_gnt", int'(gnt2), (i % 2 == 0) ? 2 : 0);
      chk("h0_busy", int'(busy2), (i % 2 == 0) ? 1 : 0);
      if (i == 1) chk("h0_q", int'(q2), 'h3C);
    end
    req2 = '0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
